// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the RISC datapath.
// Each instruction runs fetch (T0-T2), decode (T3) and execute (T4-T7).
// Memory accesses in T1, T6 (ld) and T7 (st) wait on mem_ready. A wait of
// MEM_TIMEOUT cycles sets the sticky mem_err flag and parks the unit in HALT.
// All outputs are registers loaded from the state being entered. A state's
// strobes are therefore visible for exactly the cycles that state is current.
// The opcode is taken from ir on the T2->T3 edge, so ir must hold the fetched
// word by the end of T2.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, an undefined
// opcode traps to HALT and sets the sticky illegal_op output. When it is not
// defined, undefined opcodes run as nop.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        c_out,
  output logic        con_in,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        mem_err
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_op
`endif
);

  // State encoding.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  // Opcode values.
  localparam logic [OPW-1:0] OP_LD        = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI       = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST        = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ALU_FIRST = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ALU_LAST  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ADDI      = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI      = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI       = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_BR        = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR        = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_NOP       = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT      = OPW'(5'b11011);

  // Instruction classes. Each class shares one execute sequence.
  localparam logic [3:0] CL_ALU  = 4'd0;
  localparam logic [3:0] CL_IMM  = 4'd1;
  localparam logic [3:0] CL_LDI  = 4'd2;
  localparam logic [3:0] CL_LD   = 4'd3;
  localparam logic [3:0] CL_ST   = 4'd4;
  localparam logic [3:0] CL_BR   = 4'd5;
  localparam logic [3:0] CL_JR   = 4'd6;
  localparam logic [3:0] CL_NOP  = 4'd7;
  localparam logic [3:0] CL_HALT = 4'd8;
  localparam logic [3:0] CL_ILL  = 4'd9;

  // ALU operation codes used outside the R-type group.
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam int              CW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic mem_read;
    logic mem_write;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic c_out;
    logic con_in;
  } strobe_t;

  // Map an opcode to the execute sequence it uses.
  function automatic logic [3:0] op_class(input logic [OPW-1:0] op);
    logic [3:0] cls;
    if ((op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST)) begin
      cls = CL_ALU;
    end else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI: cls = CL_IMM;
        OP_LDI:                   cls = CL_LDI;
        OP_LD:                    cls = CL_LD;
        OP_ST:                    cls = CL_ST;
        OP_BR:                    cls = CL_BR;
        OP_JR:                    cls = CL_JR;
        OP_NOP:                   cls = CL_NOP;
        OP_HALT:                  cls = CL_HALT;
        default:                  cls = CL_ILL;
      endcase
    end
    return cls;
  endfunction

  // Map an immediate opcode to the ALU operation it performs.
  function automatic logic [4:0] imm_alu(input logic [OPW-1:0] op);
    logic [4:0] code;
    case (op)
      OP_ADDI: code = ALU_ADD;
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      default: code = 5'b00000;
    endcase
    return code;
  endfunction

  logic [3:0]     state_r;
  logic [3:0]     nxt_state_s;
  logic [CW-1:0]  wait_cnt_r;
  logic [3:0]     cls_r;
  logic [OPW-1:0] opc_r;
  logic [OPW-1:0] ir_op_s;
  logic [3:0]     nxt_cls_s;
  logic [OPW-1:0] nxt_opc_s;
  logic           wait_s;
  logic           timeout_s;
  strobe_t        strb_r;
  strobe_t        nxt_strb_s;
  logic [4:0]     alu_op_r;
  logic [4:0]     nxt_alu_s;
  logic           run_r;
  logic           nxt_run_s;
  logic           mem_err_r;
  logic           unused_ir_s;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic           trap_s;
  logic           illegal_r;
`endif

  assign ir_op_s     = ir[31 -: OPW];
  assign unused_ir_s = ^ir[31-OPW:0];

  // The T3 strobes come straight from ir. Later steps use the opcode latched at T2.
  assign nxt_cls_s = (state_r == S_T2) ? op_class(ir_op_s) : cls_r;
  assign nxt_opc_s = (state_r == S_T2) ? ir_op_s : opc_r;

  // These states wait on a memory access and count the cycles without mem_ready.
  assign wait_s = (state_r == S_T1) ||
                  ((state_r == S_T6) && (cls_r == CL_LD)) ||
                  ((state_r == S_T7) && (cls_r == CL_ST));
  assign timeout_s = wait_s && !mem_ready && (wait_cnt_r == TO_LAST);

  // Next-state selection for the fetch/decode/execute sequence.
  always_comb begin
    nxt_state_s = state_r;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap_s = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) nxt_state_s = S_T0;
        else       nxt_state_s = S_IDLE;
      end
      S_T0: nxt_state_s = S_T1;
      S_T1: begin
        if (mem_ready)      nxt_state_s = S_T2;
        else if (timeout_s) nxt_state_s = S_HALT;
        else                nxt_state_s = S_T1;
      end
      S_T2: nxt_state_s = S_T3;
      S_T3: begin
        case (cls_r)
          CL_ALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_BR: nxt_state_s = S_T4;
          CL_HALT: nxt_state_s = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          CL_ILL: begin
            nxt_state_s = S_HALT;
            trap_s      = 1'b1;
          end
`endif
          default: nxt_state_s = S_T0;
        endcase
      end
      S_T4: nxt_state_s = S_T5;
      S_T5: begin
        case (cls_r)
          CL_LD, CL_ST, CL_BR: nxt_state_s = S_T6;
          default:             nxt_state_s = S_T0;
        endcase
      end
      S_T6: begin
        case (cls_r)
          CL_LD: begin
            if (mem_ready)      nxt_state_s = S_T7;
            else if (timeout_s) nxt_state_s = S_HALT;
            else                nxt_state_s = S_T6;
          end
          CL_ST:   nxt_state_s = S_T7;
          default: nxt_state_s = S_T0;
        endcase
      end
      S_T7: begin
        if (cls_r != CL_ST)  nxt_state_s = S_T0;
        else if (mem_ready)  nxt_state_s = S_T0;
        else if (timeout_s)  nxt_state_s = S_HALT;
        else                 nxt_state_s = S_T7;
      end
      S_HALT:  nxt_state_s = S_HALT;
      default: nxt_state_s = S_IDLE;
    endcase
  end

  // Strobes, ALU code and run flag for the state about to be entered.
  always_comb begin
    nxt_strb_s = '0;
    nxt_alu_s  = 5'b00000;
    nxt_run_s  = (nxt_state_s != S_IDLE) && (nxt_state_s != S_HALT);
    case (nxt_state_s)
      S_T0: begin
        nxt_strb_s.pc_out = 1'b1;
        nxt_strb_s.mar_in = 1'b1;
        nxt_strb_s.inc_pc = 1'b1;
        nxt_strb_s.z_in   = 1'b1;
      end
      S_T1: begin
        nxt_strb_s.zlow_out = 1'b1;
        nxt_strb_s.pc_in    = 1'b1;
        nxt_strb_s.mem_read = 1'b1;
        nxt_strb_s.mdr_in   = 1'b1;
      end
      S_T2: begin
        nxt_strb_s.mdr_out = 1'b1;
        nxt_strb_s.ir_in   = 1'b1;
      end
      S_T3: begin
        case (nxt_cls_s)
          CL_ALU, CL_IMM: begin
            nxt_strb_s.grb  = 1'b1;
            nxt_strb_s.rout = 1'b1;
            nxt_strb_s.y_in = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            nxt_strb_s.grb   = 1'b1;
            nxt_strb_s.baout = 1'b1;
            nxt_strb_s.y_in  = 1'b1;
          end
          CL_BR: begin
            nxt_strb_s.gra    = 1'b1;
            nxt_strb_s.rout   = 1'b1;
            nxt_strb_s.con_in = 1'b1;
          end
          CL_JR: begin
            nxt_strb_s.gra   = 1'b1;
            nxt_strb_s.rout  = 1'b1;
            nxt_strb_s.pc_in = 1'b1;
          end
          default: nxt_strb_s = '0;
        endcase
      end
      S_T4: begin
        case (nxt_cls_s)
          CL_ALU: begin
            nxt_strb_s.grc  = 1'b1;
            nxt_strb_s.rout = 1'b1;
            nxt_strb_s.z_in = 1'b1;
            nxt_alu_s       = 5'(nxt_opc_s);
          end
          CL_IMM: begin
            nxt_strb_s.c_out = 1'b1;
            nxt_strb_s.z_in  = 1'b1;
            nxt_alu_s        = imm_alu(nxt_opc_s);
          end
          CL_LDI, CL_LD, CL_ST: begin
            nxt_strb_s.c_out = 1'b1;
            nxt_strb_s.z_in  = 1'b1;
            nxt_alu_s        = ALU_ADD;
          end
          CL_BR: begin
            nxt_strb_s.pc_out = 1'b1;
            nxt_strb_s.y_in   = 1'b1;
          end
          default: nxt_strb_s = '0;
        endcase
      end
      S_T5: begin
        case (nxt_cls_s)
          CL_ALU, CL_IMM, CL_LDI: begin
            nxt_strb_s.zlow_out = 1'b1;
            nxt_strb_s.gra      = 1'b1;
            nxt_strb_s.rin      = 1'b1;
          end
          CL_LD, CL_ST: begin
            nxt_strb_s.zlow_out = 1'b1;
            nxt_strb_s.mar_in   = 1'b1;
          end
          CL_BR: begin
            nxt_strb_s.c_out = 1'b1;
            nxt_strb_s.z_in  = 1'b1;
            nxt_alu_s        = ALU_ADD;
          end
          default: nxt_strb_s = '0;
        endcase
      end
      S_T6: begin
        case (nxt_cls_s)
          CL_LD: begin
            nxt_strb_s.mem_read = 1'b1;
            nxt_strb_s.mdr_in   = 1'b1;
          end
          CL_ST: begin
            nxt_strb_s.gra    = 1'b1;
            nxt_strb_s.rout   = 1'b1;
            nxt_strb_s.mdr_in = 1'b1;
          end
          CL_BR: begin
            // The branch is taken only when the condition flip-flop is set.
            nxt_strb_s.zlow_out = con_ff;
            nxt_strb_s.pc_in    = con_ff;
          end
          default: nxt_strb_s = '0;
        endcase
      end
      S_T7: begin
        case (nxt_cls_s)
          CL_LD: begin
            nxt_strb_s.mdr_out = 1'b1;
            nxt_strb_s.gra     = 1'b1;
            nxt_strb_s.rin     = 1'b1;
          end
          CL_ST:   nxt_strb_s.mem_write = 1'b1;
          default: nxt_strb_s = '0;
        endcase
      end
      default: nxt_strb_s = '0;
    endcase
  end

  // State register, memory-wait counter and the opcode latched at the T2->T3 edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      cls_r      <= CL_NOP;
      opc_r      <= OP_NOP;
    end else begin
      state_r <= nxt_state_s;
      if (wait_s && !mem_ready && !timeout_s) wait_cnt_r <= wait_cnt_r + CW'(1);
      else                                    wait_cnt_r <= '0;
      if (state_r == S_T2) begin
        cls_r <= op_class(ir_op_s);
        opc_r <= ir_op_s;
      end else begin
        cls_r <= cls_r;
        opc_r <= opc_r;
      end
    end
  end

  // Registered Moore outputs. Reset clears them asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strb_r   <= '0;
      alu_op_r <= 5'b00000;
      run_r    <= 1'b0;
    end else begin
      strb_r   <= nxt_strb_s;
      alu_op_r <= nxt_alu_s;
      run_r    <= nxt_run_s;
    end
  end

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_err_r <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_r <= 1'b0;
`endif
    end else begin
      mem_err_r <= mem_err_r | timeout_s;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_r <= illegal_r | trap_s;
`endif
    end
  end

  assign gra       = strb_r.gra;
  assign grb       = strb_r.grb;
  assign grc       = strb_r.grc;
  assign rin       = strb_r.rin;
  assign rout      = strb_r.rout;
  assign baout     = strb_r.baout;
  assign pc_out    = strb_r.pc_out;
  assign pc_in     = strb_r.pc_in;
  assign inc_pc    = strb_r.inc_pc;
  assign mar_in    = strb_r.mar_in;
  assign mdr_in    = strb_r.mdr_in;
  assign mdr_out   = strb_r.mdr_out;
  assign mem_read  = strb_r.mem_read;
  assign mem_write = strb_r.mem_write;
  assign ir_in     = strb_r.ir_in;
  assign y_in      = strb_r.y_in;
  assign z_in      = strb_r.z_in;
  assign zlow_out  = strb_r.zlow_out;
  assign c_out     = strb_r.c_out;
  assign con_in    = strb_r.con_in;
  assign alu_op    = alu_op_r;
  assign run       = run_r;
  assign mem_err   = mem_err_r;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = illegal_r;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench for control_sequencer.
// For each instruction the reference model builds the expected per-cycle
// strobe vectors from the published step lists. It also builds the mem_ready
// pattern to drive. Each scenario task compares the sampled outputs to that list.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, start, con_ff, mem_ready;
  logic [31:0] ir;
  logic gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in;
  logic mdr_in, mdr_out, mem_read, mem_write, ir_in, y_in, z_in, zlow_out, c_out, con_in;
  logic [4:0]  alu_op;
  logic        run, mem_err;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [26:0] exp_q[$];
  logic        rdy_q[$];
  logic [26:0] got_q[$];

  localparam logic [26:0] M_GRA   = 27'd1 << 26;
  localparam logic [26:0] M_GRB   = 27'd1 << 25;
  localparam logic [26:0] M_GRC   = 27'd1 << 24;
  localparam logic [26:0] M_RIN   = 27'd1 << 23;
  localparam logic [26:0] M_ROUT  = 27'd1 << 22;
  localparam logic [26:0] M_BAOUT = 27'd1 << 21;
  localparam logic [26:0] M_PCO   = 27'd1 << 20;
  localparam logic [26:0] M_PCI   = 27'd1 << 19;
  localparam logic [26:0] M_INC   = 27'd1 << 18;
  localparam logic [26:0] M_MAR   = 27'd1 << 17;
  localparam logic [26:0] M_MDRI  = 27'd1 << 16;
  localparam logic [26:0] M_MDRO  = 27'd1 << 15;
  localparam logic [26:0] M_MRD   = 27'd1 << 14;
  localparam logic [26:0] M_MWR   = 27'd1 << 13;
  localparam logic [26:0] M_IRI   = 27'd1 << 12;
  localparam logic [26:0] M_YI    = 27'd1 << 11;
  localparam logic [26:0] M_ZI    = 27'd1 << 10;
  localparam logic [26:0] M_ZLO   = 27'd1 << 9;
  localparam logic [26:0] M_COUT  = 27'd1 << 8;
  localparam logic [26:0] M_CONI  = 27'd1 << 7;
  localparam logic [26:0] M_RUN   = 27'd1 << 1;
  localparam logic [26:0] M_ERR   = 27'd1 << 0;
  localparam logic [26:0] V_T0    = M_PCO | M_MAR | M_INC | M_ZI | M_RUN;
  localparam logic [26:0] V_T1    = M_ZLO | M_PCI | M_MRD | M_MDRI | M_RUN;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ir(ir), .con_ff(con_ff),
    .mem_ready(mem_ready), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .baout(baout), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_read(mem_read), .mem_write(mem_write),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .c_out(c_out),
    .con_in(con_in), .alu_op(alu_op), .run(run), .mem_err(mem_err)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [26:0] obs();
    return {gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in, mdr_in,
            mdr_out, mem_read, mem_write, ir_in, y_in, z_in, zlow_out, c_out, con_in,
            alu_op, run, mem_err};
  endfunction

  function automatic logic [26:0] alu(input logic [4:0] code);
    return 27'(code) << 2;
  endfunction

  task automatic push(input logic [26:0] v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endtask

  // Reference model: the expected cycles for one instruction, starting at T0.
  // wf is the number of fetch wait cycles and wm the number of data wait cycles.
  task automatic build(input logic [4:0] op, input logic con, input int wf, input int wm);
    exp_q.delete();
    rdy_q.delete();
    push(V_T0, 1'b1);
    for (int k = 0; k <= wf; k++) push(V_T1, (k == wf));
    push(M_MDRO | M_IRI | M_RUN, 1'b1);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YI | M_RUN, 1'b1);
      push(M_GRC | M_ROUT | M_ZI | alu(op) | M_RUN, 1'b1);
      push(M_ZLO | M_GRA | M_RIN | M_RUN, 1'b1);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YI | M_RUN, 1'b1);
      push(M_COUT | M_ZI | M_RUN |
           alu((op == 5'd12) ? 5'd3 : ((op == 5'd13) ? 5'd5 : 5'd6)), 1'b1);
      push(M_ZLO | M_GRA | M_RIN | M_RUN, 1'b1);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YI | M_RUN, 1'b1);
      push(M_COUT | M_ZI | alu(5'd3) | M_RUN, 1'b1);
      if (op == 5'd1) begin
        push(M_ZLO | M_GRA | M_RIN | M_RUN, 1'b1);
      end else begin
        push(M_ZLO | M_MAR | M_RUN, 1'b1);
        if (op == 5'd0) begin
          for (int k = 0; k <= wm; k++) push(M_MRD | M_MDRI | M_RUN, (k == wm));
          push(M_MDRO | M_GRA | M_RIN | M_RUN, 1'b1);
        end else begin
          push(M_GRA | M_ROUT | M_MDRI | M_RUN, 1'b1);
          for (int k = 0; k <= wm; k++) push(M_MWR | M_RUN, (k == wm));
        end
      end
    end else if (op == 5'd18) begin
      push(M_GRA | M_ROUT | M_CONI | M_RUN, 1'b1);
      push(M_PCO | M_YI | M_RUN, 1'b1);
      push(M_COUT | M_ZI | alu(5'd3) | M_RUN, 1'b1);
      push(con ? (M_ZLO | M_PCI | M_RUN) : M_RUN, 1'b1);
    end else if (op == 5'd19) begin
      push(M_GRA | M_ROUT | M_PCI | M_RUN, 1'b1);
    end else begin
      push(M_RUN, 1'b1);
    end
  endtask

  // Step through the expected list, sampling outputs and driving mem_ready.
  task automatic walk();
    got_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      got_q.push_back(obs());
      mem_ready = rdy_q[i];
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; mem_ready = 1'b1; con_ff = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mem_ready = 1'b1; con_ff = 1'b0; ir = 32'h0;
    #12;
    n_cmp++;
    if (obs() !== 27'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs()); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_cmp++;
    if (illegal_op !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
`endif
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (obs() !== 27'd0) begin n_bad++; $display("FAIL idle_no_start: got %h want 0", obs()); end
  endtask

  task automatic test_add();
    int c0;
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    build(5'd3, 1'b0, 0, 0);
    c0 = cyc;
    do_start();
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL add step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if ((cyc - c0) !== 7 || obs() !== V_T0) begin
      n_bad++; $display("FAIL add_back_to_t0: cycle %0d outputs %h want cycle 7 outputs %h", cyc - c0, obs(), V_T0);
    end
  endtask

  task automatic test_ld();
    int nrd;
    logic [26:0] v;
    ir = {5'b00000, 4'd4, 4'd2, 19'h10};
    build(5'd0, 1'b0, 0, 3);
    walk();
    nrd = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      v = got_q[i];
      if (((v & M_MRD) != 27'd0) && ((v & M_PCI) == 27'd0)) nrd++;
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ld step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (nrd !== 4) begin n_bad++; $display("FAIL ld_read_hold: got %0d cycles want 4", nrd); end
  endtask

  task automatic test_branch();
    logic [26:0] v;
    for (int c = 0; c < 2; c++) begin
      ir = {5'b10010, 4'd5, 23'h40};
      con_ff = (c == 1);
      build(5'd18, con_ff, 0, 0);
      walk();
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL br%0d step %0d: got %h want %h", c, i, got_q[i], exp_q[i]);
        end
      end
      v = got_q[6];
      n_cmp++;
      if (v[19] !== con_ff || v[9] !== con_ff) begin
        n_bad++; $display("FAIL br_t6_con%0d: pc_in %b zlow_out %b want %b", c, v[19], v[9], con_ff);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[$] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd11, 5'd12, 5'd13,
                           5'd14, 5'd18, 5'd19, 5'd26};
    logic [4:0] op;
    logic       con;
`ifndef CTRL_ILLEGAL_TRAP_EN
    ops.push_back(5'd15);
    ops.push_back(5'd20);
    ops.push_back(5'd31);
`endif
    for (int n = 0; n < 40; n++) begin
      op  = ops[$urandom_range(0, ops.size() - 1)];
      con = 1'($urandom_range(0, 1));
      ir  = {op, 27'($urandom)};
      con_ff = con;
      build(op, con, $urandom_range(0, 4), $urandom_range(0, 5));
      walk();
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand op %b step %0d: got %h want %h", op, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_halt_op();
    ir = {5'b11011, 27'd0};
    build(5'd27, 1'b0, 1, 0);
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL halt step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      do_start();
      n_cmp++;
      if (obs() !== 27'd0) begin n_bad++; $display("FAIL halt_stays %0d: got %h want 0", k, obs()); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ir = {5'b11010, 27'd0};
    exp_q.delete();
    rdy_q.delete();
    push(V_T0, 1'b0);
    for (int k = 0; k < 15; k++) push(V_T1, 1'b0);
    do_start();
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL timeout step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs() !== M_ERR) begin n_bad++; $display("FAIL timeout_err: got %h want %h", obs(), M_ERR); end
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_start();
      n_cmp++;
      if (obs() !== M_ERR) begin n_bad++; $display("FAIL timeout_sticky %0d: got %h want %h", k, obs(), M_ERR); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir = {5'b00010, 4'd6, 4'd1, 19'h8};
    build(5'd2, 1'b0, 0, 3);
    while (exp_q.size() > 7) begin
      void'(exp_q.pop_back());
      void'(rdy_q.pop_back());
    end
    do_start();
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL st_pre step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs() !== (M_MWR | M_RUN)) begin n_bad++; $display("FAIL st_t7: got %h want %h", obs(), M_MWR | M_RUN); end
    mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 27'd0) begin n_bad++; $display("FAIL async_drop: got %h want 0", obs()); end
    mem_ready = 1'b1;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (obs() !== 27'd0) begin n_bad++; $display("FAIL post_reset_idle: got %h want 0", obs()); end
    ir = {5'b00100, 27'h123};
    build(5'd4, 1'b0, 0, 0);
    do_start();
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL refetch step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ir = {5'b11111, 27'd0};
    build(5'd31, 1'b0, 0, 0);
    do_start();
    walk();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL illegal step %0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    n_cmp++;
    if (obs() !== 27'd0 || illegal_op !== 1'b1) begin
      n_bad++; $display("FAIL illegal_trap: outputs %h illegal_op %b want 0 and 1", obs(), illegal_op);
    end
`else
    n_cmp++;
    if (obs() !== V_T0) begin n_bad++; $display("FAIL illegal_as_nop: got %h want %h", obs(), V_T0); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_branch();
    test_random();
    test_halt_op();
    test_timeout();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
